packet_receiver_sink: RTL and testbench

- Destination-side receiver for the 38-bit packets launched by the local controller ring.
- Sits at each compute-tile ingress and snoops the packet bus.
- Accepts packets whose destination vector selects this tile and strips the header and address.
- Buffers the I/Q payload in a first-word-fall-through FIFO and presents it to the tile with a valid/ready handshake.
- Tracks window boundaries, live/prefetch counts and overflow.

---
 rtl/packet_receiver_sink.sv | 151 +++++++++++++++
 tb/tb_packet_receiver_sink.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/packet_receiver_sink.sv
// Purpose: tile-ingress sink; accepts ring packets addressed to this node and queues the I/Q payload in a FWFT FIFO.
// Latency: packet registered at the first edge, written at the second; out_valid rises after that second edge.
// Backpressure: none upstream; a match arriving at a full FIFO with no pop is dropped and sets sticky overflow.
module packet_receiver_sink #(
    parameter int datawidth            = 16,
    parameter int address_vector_width = 4,
    parameter int node_index           = 0,
    parameter int fifo_depth           = 8,
    parameter int count_width          = 8,
    localparam int packet_width        = 2 + 2*datawidth + address_vector_width
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [packet_width-1:0]       packet_in,
    input  logic                          scenario_update,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [2*datawidth-1:0]        out_data,
    output logic                          out_prefetch,
    output logic                          out_last,
    output logic                          window_done,
    output logic                          overflow,
    output logic [count_width-1:0]        sample_count,
    output logic [count_width-1:0]        prefetch_count,
    output logic [$clog2(fifo_depth):0]   fifo_level
);

    localparam int PAYLOAD_W = 2*datawidth;
    localparam int ENTRY_W   = PAYLOAD_W + 2;
    localparam int PTR_W     = $clog2(fifo_depth);
    localparam int LVL_W     = PTR_W + 1;
    localparam logic [address_vector_width-1:0] NODE_MASK =
        address_vector_width'(1) << node_index;

    typedef enum logic {IDLE, ACTIVE} state_t;

    logic [packet_width-1:0]         pkt_q;
    logic [1:0]                      hdr;
    logic [PAYLOAD_W-1:0]            payload;
    logic [address_vector_width-1:0] dest;
    logic                            match;
    logic                            full;
    logic                            push;
    logic                            pop;
    logic                            drop;
    logic [ENTRY_W-1:0]              mem [fifo_depth];
    logic [ENTRY_W-1:0]              head;
    logic [PTR_W-1:0]                wr_ptr;
    logic [PTR_W-1:0]                rd_ptr;
    logic [LVL_W-1:0]                level_q;
    state_t                          state_q;
    state_t                          state_d;

    // Field decode of the registered packet and the push/pop/drop decisions.
    // The mask-and-reduce form keeps other destination bits don't-care (multicast).
    always_comb begin
        hdr       = pkt_q[packet_width-1 -: 2];
        payload   = pkt_q[address_vector_width +: PAYLOAD_W];
        dest      = pkt_q[address_vector_width-1:0];
        match     = (hdr != 2'b00) && (|(dest & NODE_MASK));
        full      = (level_q == LVL_W'(fifo_depth));
        out_valid = (level_q != '0);
        pop       = out_valid && out_ready && !scenario_update;
        push      = match && (!full || pop) && !scenario_update;
        drop      = match && full && !pop && !scenario_update;
        head      = mem[rd_ptr];
    end

    // Head presentation; gated so nothing stale shows while empty.
    always_comb begin
        out_data     = out_valid ? head[ENTRY_W-1:2] : '0;
        out_prefetch = out_valid & head[1];
        out_last     = out_valid & head[0];
        fifo_level   = level_q;
    end

    // Stage-1 input register; a flush also discards whatever is arriving.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset)               pkt_q <= '0;
        else if (scenario_update) pkt_q <= '0;
        else                      pkt_q <= packet_in;
    end

    // Payload storage; contents need no reset because level gates visibility.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= {payload, (hdr == 2'b10), (hdr == 2'b11)};
    end

    // Pointers wrap naturally (power-of-two depth); level disambiguates full/empty.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else if (scenario_update) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      level_q <= level_q + LVL_W'(1);
            else if (pop && !push) level_q <= level_q - LVL_W'(1);
        end
    end

    // Saturating sample counters and sticky overflow flag.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            sample_count   <= '0;
            prefetch_count <= '0;
            overflow       <= 1'b0;
        end else if (scenario_update) begin
            sample_count   <= '0;
            prefetch_count <= '0;
            overflow       <= 1'b0;
        end else begin
            if (push && hdr[0] && (sample_count != '1))
                sample_count <= sample_count + count_width'(1);
            if (push && (hdr == 2'b10) && (prefetch_count != '1))
                prefetch_count <= prefetch_count + count_width'(1);
            if (drop)
                overflow <= 1'b1;
        end
    end

    // Window FSM state register.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Window FSM next state; window_done pulses while an end-of-window packet is being accepted.
    always_comb begin
        state_d     = state_q;
        window_done = 1'b0;
        if (scenario_update) begin
            state_d = IDLE;
        end else if (push) begin
            case (hdr)
                2'b01: state_d = ACTIVE;
                2'b11: begin
                    state_d     = IDLE;
                    window_done = 1'b1;
                end
                default: state_d = state_q;
            endcase
        end
    end

endmodule

// File: tb/tb_packet_receiver_sink.sv
module tb_packet_receiver_sink;

    logic        CLK = 1'b0;
    logic        reset;
    logic [37:0] packet_in;
    logic        scenario_update;
    logic        out_ready;

    logic        out_valid, out_prefetch, out_last, window_done, overflow;
    logic [31:0] out_data;
    logic [7:0]  sample_count, prefetch_count;
    logic [3:0]  fifo_level;

    logic        n1_valid, n1_prefetch, n1_last, n1_window_done, n1_overflow;
    logic [31:0] n1_data;
    logic [7:0]  n1_sample_count, n1_prefetch_count;
    logic [3:0]  n1_level;

    int total = 0;
    int bad   = 0;
    int wd_count = 0;
    logic [33:0] sb_q[$];

    always #5 CLK = ~CLK;

    packet_receiver_sink #(.node_index(0)) dut (
        .CLK(CLK), .reset(reset), .packet_in(packet_in),
        .scenario_update(scenario_update), .out_ready(out_ready),
        .out_valid(out_valid), .out_data(out_data), .out_prefetch(out_prefetch),
        .out_last(out_last), .window_done(window_done), .overflow(overflow),
        .sample_count(sample_count), .prefetch_count(prefetch_count),
        .fifo_level(fifo_level)
    );

    packet_receiver_sink #(.node_index(1)) dut_n1 (
        .CLK(CLK), .reset(reset), .packet_in(packet_in),
        .scenario_update(scenario_update), .out_ready(out_ready),
        .out_valid(n1_valid), .out_data(n1_data), .out_prefetch(n1_prefetch),
        .out_last(n1_last), .window_done(n1_window_done), .overflow(n1_overflow),
        .sample_count(n1_sample_count), .prefetch_count(n1_prefetch_count),
        .fifo_level(n1_level)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every handshake pops the scoreboard and compares the head.
    always @(negedge CLK) begin
        if (reset && out_valid && out_ready && !scenario_update) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_head", {30'd0, out_data, out_prefetch, out_last}, 64'h0);
            end else begin
                logic [33:0] e;
                e = sb_q.pop_front();
                chk("head", {30'd0, out_data, out_prefetch, out_last}, {30'd0, e});
            end
        end
        if (window_done) wd_count++;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic send(input logic [1:0] h, input logic [31:0] p,
                        input logic [3:0] d, input bit acc);
        packet_in = {h, p, d};
        if (acc) sb_q.push_back({p, (h == 2'b10), (h == 2'b11)});
        tick();
        packet_in = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        sb_q.delete();
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        int wd_before;
        reset = 1'b0;
        packet_in = '0;
        scenario_update = 1'b0;
        out_ready = 1'b0;
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_samples", sample_count, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_window_done", window_done, 0);
        tick();
        reset = 1'b1;
        tick();

        // Reset asserted while a packet is in flight wipes it immediately.
        send(2'b01, 32'hDEAD_BEEF, 4'b0001, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_valid", out_valid, 0);
        chk("midrst_level", fifo_level, 0);
        tick();
        reset = 1'b1;
        tick();
        tick();
        chk("midrst_after_level", fifo_level, 0);

        // Basic acceptance and two-edge latency.
        out_ready = 1'b1;
        send(2'b01, 32'h0001_0002, 4'b0001, 1'b1);
        chk("lat_edge1_valid", out_valid, 0);
        tick();
        chk("lat_edge2_valid", out_valid, 1);
        chk("lat_data", out_data, 32'h0001_0002);
        chk("lat_samples", sample_count, 1);
        tick();
        chk("lat_popped", out_valid, 0);

        // Destination filtering: bit 0 clear, bit 1 set.
        send(2'b01, 32'hAAAA_5555, 4'b0110, 1'b0);
        tick();
        chk("dest_n0_level", fifo_level, 0);
        chk("dest_n0_samples", sample_count, 1);
        chk("dest_n1_valid", n1_valid, 1);
        chk("dest_n1_data", n1_data, 32'hAAAA_5555);
        chk("dest_n1_samples", n1_sample_count, 1);
        tick();

        // Overflow: nine packets into an eight-entry FIFO with no consumer.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 9; i++)
            send(2'b01, 32'h1000_0000 + i, 4'b0001, i < 8);
        tick();
        chk("ovf_level", fifo_level, 8);
        chk("ovf_flag", overflow, 1);
        chk("ovf_samples", sample_count, 8);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("ovf_drained_valid", out_valid, 0);
        chk("ovf_sb_empty", sb_q.size(), 0);
        chk("ovf_sticky", overflow, 1);

        // Window sequence: live, live, prefetch, end-of-window.
        do_reset();
        out_ready = 1'b0;
        wd_before = wd_count;
        send(2'b01, 32'h0000_00A1, 4'b0001, 1'b1);
        send(2'b01, 32'h0000_00A2, 4'b0001, 1'b1);
        send(2'b10, 32'h0000_00A3, 4'b0001, 1'b1);
        send(2'b11, 32'h0000_00A4, 4'b0001, 1'b1);
        tick();
        chk("win_prefetch_count", prefetch_count, 1);
        chk("win_sample_count", sample_count, 3);
        chk("win_done_pulses", wd_count - wd_before, 1);
        out_ready = 1'b1;
        repeat (4) tick();
        chk("win_sb_empty", sb_q.size(), 0);

        // Full FIFO with simultaneous pop accepts the incoming packet.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++)
            send(2'b01, 32'h2000_0000 + i, 4'b0001, 1'b1);
        tick();
        chk("full_level", fifo_level, 8);
        send(2'b01, 32'h2000_0008, 4'b0001, 1'b1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("fullpop_level", fifo_level, 8);
        chk("fullpop_overflow", overflow, 0);
        chk("fullpop_samples", sample_count, 9);
        out_ready = 1'b1;
        repeat (8) tick();
        chk("fullpop_sb_empty", sb_q.size(), 0);
        chk("fullpop_valid", out_valid, 0);

        // Flush with level 5 and a packet arriving in the same cycle.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(2'b01, 32'h3000_0000 + i, 4'b0001, 1'b1);
        tick();
        chk("flush_pre_level", fifo_level, 5);
        packet_in = {2'b01, 32'h3333_3333, 4'b0001};
        scenario_update = 1'b1;
        sb_q.delete();
        tick();
        scenario_update = 1'b0;
        packet_in = '0;
        chk("flush_level", fifo_level, 0);
        chk("flush_samples", sample_count, 0);
        chk("flush_overflow", overflow, 0);
        tick();
        tick();
        chk("flush_no_ghost", out_valid, 0);

        // Sample counter saturates at 255.
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++)
            send(2'b01, 32'h4000_0000 + i, 4'b0001, 1'b1);
        tick();
        tick();
        chk("sat_samples", sample_count, 8'hFF);
        chk("sat_overflow", overflow, 0);
        chk("sat_sb_empty", sb_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
